// File: rtl/checkpoint_buffer.sv
// Circular buffer of rename/branch checkpoints: in-order allocation from fetch,
// random-access read/overwrite by ID, in-order retirement or full flush from commit.
package checkpoint_buffer_pkg;
  localparam int PHY_REG_NUM          = 16;
  localparam int GLOBAL_HISTORY_WIDTH = 8;
  localparam int LOCAL_HISTORY_WIDTH  = 8;

  typedef struct packed {
    logic [PHY_REG_NUM-1:0]          rat_phy_map_table_valid;
    logic [PHY_REG_NUM-1:0]          rat_phy_map_table_visible;
    logic [GLOBAL_HISTORY_WIDTH-1:0] global_history;
    logic [LOCAL_HISTORY_WIDTH-1:0]  local_history;
  } checkpoint_t;
endpackage

module checkpoint_buffer
  import checkpoint_buffer_pkg::*;
#(
  parameter int CHECKPOINT_BUFFER_SIZE = 8,
  parameter int CHECKPOINT_ID_WIDTH    = $clog2(CHECKPOINT_BUFFER_SIZE),
  parameter int RENAME_WIDTH           = 3,
  parameter int COMMIT_WIDTH           = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id,
  output logic                           cpbuf_fetch_new_id_valid,
  input  checkpoint_t                    fetch_cpbuf_data,
  input  logic                           fetch_cpbuf_push,
  input  logic [CHECKPOINT_ID_WIDTH-1:0] rename_cpbuf_id [RENAME_WIDTH],
  input  checkpoint_t                    rename_cpbuf_data [RENAME_WIDTH],
  input  logic [RENAME_WIDTH-1:0]        rename_cpbuf_we,
  output checkpoint_t                    cpbuf_rename_data [RENAME_WIDTH],
  input  logic [CHECKPOINT_ID_WIDTH-1:0] exbru_cpbuf_id,
  output checkpoint_t                    cpbuf_exbru_data,
  input  logic [CHECKPOINT_ID_WIDTH-1:0] commit_cpbuf_id [COMMIT_WIDTH],
  output checkpoint_t                    cpbuf_commit_data [COMMIT_WIDTH],
  input  logic [COMMIT_WIDTH-1:0]        commit_cpbuf_pop,
  input  logic                           commit_cpbuf_flush
);
  localparam int W     = CHECKPOINT_ID_WIDTH;
  localparam int PCW   = $clog2(COMMIT_WIDTH + 1);
  localparam int CNT_W = (PCW > W + 1) ? PCW : W + 1;

  // Pointers carry one extra wrap bit so full (same index, different wrap) is
  // distinguishable from empty (identical pointers).
  logic [W:0]       wptr_q, wptr_d;
  logic [W:0]       rptr_q, rptr_d;
  checkpoint_t      mem_q [CHECKPOINT_BUFFER_SIZE];
  checkpoint_t      mem_d [CHECKPOINT_BUFFER_SIZE];
  logic             full;
  logic             push_ok;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] pop_cnt;

  always_comb begin
    full      = (wptr_q[W] != rptr_q[W]) && (wptr_q[W-1:0] == rptr_q[W-1:0]);
    occupancy = CNT_W'(wptr_q - rptr_q);
    pop_req   = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      pop_req = pop_req + CNT_W'(commit_cpbuf_pop[i]);
    end
    pop_cnt = (pop_req > occupancy) ? occupancy : pop_req;
    push_ok = fetch_cpbuf_push && !full && !commit_cpbuf_flush && !rst;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (commit_cpbuf_flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + (W+1)'(1);
      rptr_d = rptr_q + pop_cnt[W:0];
    end

    // Rename ports apply in ascending order so the highest index wins; a push
    // lands last and therefore overrides any rename write to the same entry.
    mem_d = mem_q;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (rename_cpbuf_we[i]) mem_d[rename_cpbuf_id[i]] = rename_cpbuf_data[i];
    end
    if (push_ok) mem_d[wptr_q[W-1:0]] = fetch_cpbuf_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Fetch handshake: cpbuf_fetch_new_id_valid acts as ready; a push is accepted
  // at the edge only while it is high, and a push while it is low is dropped.
  assign cpbuf_fetch_new_id       = wptr_q[W-1:0];
  assign cpbuf_fetch_new_id_valid = !full;

  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) cpbuf_rename_data[i] = mem_q[rename_cpbuf_id[i]];
    for (int i = 0; i < COMMIT_WIDTH; i++) cpbuf_commit_data[i] = mem_q[commit_cpbuf_id[i]];
    cpbuf_exbru_data = mem_q[exbru_cpbuf_id];
  end
endmodule

// File: tb/tb_checkpoint_buffer.sv
// Directed bench for checkpoint_buffer: queue-level model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_checkpoint_buffer;
  import checkpoint_buffer_pkg::*;

  localparam int SIZE = 8;
  localparam int IW   = 3;
  localparam int RW   = 3;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [IW-1:0]   cpbuf_fetch_new_id;
  logic            cpbuf_fetch_new_id_valid;
  checkpoint_t     fetch_cpbuf_data;
  logic            fetch_cpbuf_push;
  logic [IW-1:0]   rename_cpbuf_id [RW];
  checkpoint_t     rename_cpbuf_data [RW];
  logic [RW-1:0]   rename_cpbuf_we;
  checkpoint_t     cpbuf_rename_data [RW];
  logic [IW-1:0]   exbru_cpbuf_id;
  checkpoint_t     cpbuf_exbru_data;
  logic [IW-1:0]   commit_cpbuf_id [CW];
  checkpoint_t     cpbuf_commit_data [CW];
  logic [CW-1:0]   commit_cpbuf_pop;
  logic            commit_cpbuf_flush;

  int tests = 0;
  int fails = 0;

  checkpoint_buffer #(
    .CHECKPOINT_BUFFER_SIZE(SIZE), .CHECKPOINT_ID_WIDTH(IW),
    .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpbuf_fetch_new_id(cpbuf_fetch_new_id),
    .cpbuf_fetch_new_id_valid(cpbuf_fetch_new_id_valid),
    .fetch_cpbuf_data(fetch_cpbuf_data), .fetch_cpbuf_push(fetch_cpbuf_push),
    .rename_cpbuf_id(rename_cpbuf_id), .rename_cpbuf_data(rename_cpbuf_data),
    .rename_cpbuf_we(rename_cpbuf_we), .cpbuf_rename_data(cpbuf_rename_data),
    .exbru_cpbuf_id(exbru_cpbuf_id), .cpbuf_exbru_data(cpbuf_exbru_data),
    .commit_cpbuf_id(commit_cpbuf_id), .cpbuf_commit_data(cpbuf_commit_data),
    .commit_cpbuf_pop(commit_cpbuf_pop), .commit_cpbuf_flush(commit_cpbuf_flush)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic checkpoint_t mk(input logic [7:0] gh);
    checkpoint_t c;
    c.global_history            = gh;
    c.local_history             = gh ^ 8'h5a;
    c.rat_phy_map_table_valid   = {gh, ~gh};
    c.rat_phy_map_table_visible = {~gh, gh};
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: occupancy count and head index over a plain array.
  checkpoint_t m_mem [SIZE];
  bit          m_known [SIZE];
  int          m_head = 0;
  int          m_count = 0;
  int          m_pops;

  always @(posedge clk) begin
    for (int i = 0; i < RW; i++) begin
      if (rename_cpbuf_we[i]) begin
        m_mem[int'(rename_cpbuf_id[i])]   = rename_cpbuf_data[i];
        m_known[int'(rename_cpbuf_id[i])] = 1'b1;
      end
    end
    if (rst || commit_cpbuf_flush) begin
      m_head  = 0;
      m_count = 0;
    end else begin
      m_pops = $countones(commit_cpbuf_pop);
      if (m_pops > m_count) m_pops = m_count;
      if (fetch_cpbuf_push && m_count < SIZE) begin
        m_mem[(m_head + m_count) % SIZE]   = fetch_cpbuf_data;
        m_known[(m_head + m_count) % SIZE] = 1'b1;
        m_count++;
      end
      m_head  = (m_head + m_pops) % SIZE;
      m_count = m_count - m_pops;
    end
  end

  // Scoreboard compare, every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_new_id", 64'(cpbuf_fetch_new_id), 64'((m_head + m_count) % SIZE));
      chk("m_valid", 64'(cpbuf_fetch_new_id_valid), 64'(m_count < SIZE));
      for (int i = 0; i < RW; i++)
        if (m_known[int'(rename_cpbuf_id[i])])
          chk($sformatf("m_rename_rd%0d", i), 64'(cpbuf_rename_data[i]),
              64'(m_mem[int'(rename_cpbuf_id[i])]));
      for (int i = 0; i < CW; i++)
        if (m_known[int'(commit_cpbuf_id[i])])
          chk($sformatf("m_commit_rd%0d", i), 64'(cpbuf_commit_data[i]),
              64'(m_mem[int'(commit_cpbuf_id[i])]));
      if (m_known[int'(exbru_cpbuf_id)])
        chk("m_exbru_rd", 64'(cpbuf_exbru_data), 64'(m_mem[int'(exbru_cpbuf_id)]));
    end
  end

  // Driver helpers
  task automatic set_all_ids(input logic [IW-1:0] id);
    for (int i = 0; i < RW; i++) rename_cpbuf_id[i] = id;
    for (int i = 0; i < CW; i++) commit_cpbuf_id[i] = id;
    exbru_cpbuf_id = id;
  endtask

  task automatic chk_ptr(input string name, input int id, input bit valid);
    chk({name, "_id"}, 64'(cpbuf_fetch_new_id), 64'(id));
    chk({name, "_valid"}, 64'(cpbuf_fetch_new_id_valid), 64'(valid));
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    fetch_cpbuf_push = 1'b1;
    for (int k = 0; k < n; k++) begin
      fetch_cpbuf_data = mk(base + 8'(k));
      tick();
    end
    fetch_cpbuf_push = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_cpbuf_data = '0;
    fetch_cpbuf_push = 1'b0;
    rename_cpbuf_we = '0;
    for (int i = 0; i < RW; i++) rename_cpbuf_data[i] = '0;
    set_all_ids('0);
    commit_cpbuf_pop = '0;
    commit_cpbuf_flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_ptr("reset", 0, 1'b1);

    // Two pushes, then per-port combinational reads
    fetch_cpbuf_push = 1'b1;
    fetch_cpbuf_data = mk(8'd1);
    tick();
    chk_ptr("push1", 1, 1'b1);
    fetch_cpbuf_data = mk(8'd3);
    tick();
    fetch_cpbuf_push = 1'b0;
    chk_ptr("push2", 2, 1'b1);
    for (int p = 0; p < RW; p++) begin
      set_all_ids(3'd1);
      rename_cpbuf_id[p] = 3'd0;
      #1;
      chk($sformatf("rename%0d_id0", p), 64'(cpbuf_rename_data[p].global_history), 64'd1);
      chk("exbru_id1", 64'(cpbuf_exbru_data.global_history), 64'd3);
    end
    set_all_ids(3'd0);
    exbru_cpbuf_id = 3'd1;
    #1;
    chk("exbru_id1_alone", 64'(cpbuf_exbru_data.global_history), 64'd3);
    chk("rename0_id0_b", 64'(cpbuf_rename_data[0].global_history), 64'd1);
    for (int p = 0; p < CW; p++) begin
      set_all_ids(3'd1);
      commit_cpbuf_id[p] = 3'd0;
      #1;
      chk($sformatf("commit%0d_id0", p), 64'(cpbuf_commit_data[p].global_history), 64'd1);
      chk("rename0_id1", 64'(cpbuf_rename_data[0].global_history), 64'd3);
    end
    tick();

    // Rename writes, one port at a time, visible the cycle after
    set_all_ids(3'd0);
    for (int p = 0; p < RW; p++) begin
      rename_cpbuf_we = '0;
      rename_cpbuf_we[p] = 1'b1;
      rename_cpbuf_data[p] = mk(8'd7 + 8'(p));
      tick();
      rename_cpbuf_we = '0;
      chk($sformatf("rename_wr%0d", p), 64'(cpbuf_rename_data[p].global_history), 64'(7 + p));
    end

    // All rename ports hit ID 1: highest port wins
    set_all_ids(3'd1);
    for (int p = 0; p < RW; p++) rename_cpbuf_data[p] = mk(8'h20 + 8'(p));
    rename_cpbuf_we = '1;
    tick();
    rename_cpbuf_we = '0;
    chk("rename_collision", 64'(cpbuf_rename_data[0].global_history), 64'h22);

    // Push and rename write to the same entry: push wins
    set_all_ids(3'd2);
    fetch_cpbuf_push = 1'b1;
    fetch_cpbuf_data = mk(8'h55);
    rename_cpbuf_we = 3'b001;
    rename_cpbuf_data[0] = mk(8'h66);
    tick();
    fetch_cpbuf_push = 1'b0;
    rename_cpbuf_we = '0;
    chk("push_over_rename", 64'(cpbuf_rename_data[0].global_history), 64'h55);
    chk_ptr("push3", 3, 1'b1);

    // Flush ignores push/pop but keeps the rename write
    set_all_ids(3'd5);
    commit_cpbuf_flush = 1'b1;
    fetch_cpbuf_push = 1'b1;
    fetch_cpbuf_data = mk(8'h99);
    commit_cpbuf_pop = '1;
    rename_cpbuf_we = 3'b001;
    rename_cpbuf_data[0] = mk(8'h77);
    tick();
    commit_cpbuf_flush = 1'b0;
    fetch_cpbuf_push = 1'b0;
    commit_cpbuf_pop = '0;
    rename_cpbuf_we = '0;
    chk_ptr("flush", 0, 1'b1);
    chk("flush_rename_wr", 64'(cpbuf_rename_data[0].global_history), 64'h77);

    // Fill from empty, then a rejected push
    set_all_ids(3'd0);
    for (int k = 0; k < SIZE; k++) begin
      chk_ptr($sformatf("fill%0d", k), k, 1'b1);
      push_n(1, 8'h10 + 8'(k));
    end
    chk_ptr("full", 0, 1'b0);
    push_n(1, 8'hee);
    chk_ptr("push_when_full", 0, 1'b0);
    chk("full_push_no_write", 64'(cpbuf_exbru_data.global_history), 64'h10);

    // Drain one per cycle
    commit_cpbuf_pop = 4'b0001;
    for (int k = 0; k < SIZE; k++) begin
      tick();
      chk_ptr($sformatf("drain%0d", k), 0, 1'b1);
    end
    commit_cpbuf_pop = 4'b1111;
    tick();
    commit_cpbuf_pop = '0;
    push_n(1, 8'h40);
    chk_ptr("pop_empty_ignored", 1, 1'b1);
    push_n(SIZE - 1, 8'h41);
    chk_ptr("refull", 0, 1'b0);

    // Push and pop together while full: only the pop takes effect
    fetch_cpbuf_push = 1'b1;
    fetch_cpbuf_data = mk(8'hab);
    commit_cpbuf_pop = 4'b0100;
    tick();
    commit_cpbuf_pop = '0;
    chk_ptr("full_push_pop", 0, 1'b1);
    tick();
    fetch_cpbuf_push = 1'b0;
    chk_ptr("push_after_pop", 1, 1'b0);

    // Multi-bit pop and clamping to occupancy
    commit_cpbuf_flush = 1'b1;
    tick();
    commit_cpbuf_flush = 1'b0;
    push_n(5, 8'h30);
    chk_ptr("five", 5, 1'b1);
    commit_cpbuf_pop = 4'b1011;
    tick();
    commit_cpbuf_pop = 4'b1111;
    tick();
    commit_cpbuf_pop = '0;
    chk_ptr("pop_clamped", 5, 1'b1);
    push_n(7, 8'h50);
    chk_ptr("seven_after_clamp", 4, 1'b1);
    push_n(1, 8'h57);
    chk_ptr("full_after_clamp", 5, 1'b0);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/checkpoint_buffer.md
Name: checkpoint_buffer

Overview:
- Circular buffer of branch-prediction/rename checkpoints (type checkpoint_t from common.svh: rat_phy_map_table_valid, rat_phy_map_table_visible, global_history, local_history).
- Fetch allocates entries in order; rename, exbru and commit read entries combinationally by ID; rename can overwrite entries; commit retires entries in order or flushes the whole buffer.

Parameters:
- CHECKPOINT_BUFFER_SIZE, `CHECKPOINT_BUFFER_SIZE (config.svh), number of entries; power of two, at least 4.
- CHECKPOINT_ID_WIDTH, `CHECKPOINT_ID_WIDTH, equal to clog2(CHECKPOINT_BUFFER_SIZE), width of an entry ID.
- RENAME_WIDTH, `RENAME_WIDTH, number of rename read/write ports.
- COMMIT_WIDTH, `COMMIT_WIDTH, number of commit read/pop ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpbuf_fetch_new_id  out  ID_WIDTH  ID the next push will occupy (write pointer).
- cpbuf_fetch_new_id_valid  out  1  high when the buffer is not full.
- fetch_cpbuf_data  in  checkpoint_t  data written on a push.
- fetch_cpbuf_push  in  1  allocate entry cpbuf_fetch_new_id.
- rename_cpbuf_id[RENAME_WIDTH]  in  ID_WIDTH each  rename read/write address per port.
- rename_cpbuf_data[RENAME_WIDTH]  in  checkpoint_t each  rename write data.
- rename_cpbuf_we  in  RENAME_WIDTH  per-port write enable.
- cpbuf_rename_data[RENAME_WIDTH]  out  checkpoint_t each  entry at rename_cpbuf_id[i].
- exbru_cpbuf_id  in  ID_WIDTH  exbru read address.
- cpbuf_exbru_data  out  checkpoint_t  entry at exbru_cpbuf_id.
- commit_cpbuf_id[COMMIT_WIDTH]  in  ID_WIDTH each  commit read address.
- cpbuf_commit_data[COMMIT_WIDTH]  out  checkpoint_t each  entry at commit_cpbuf_id[i].
- commit_cpbuf_pop  in  COMMIT_WIDTH  pop request bits.
- commit_cpbuf_flush  in  1  empty the buffer.

Behaviour:
- State: storage array of CHECKPOINT_BUFFER_SIZE checkpoint_t; write pointer wptr and read pointer rptr, each ID_WIDTH wide with an extra wrap bit (or an occupancy counter) to tell full from empty.
- Reset (rst high at an edge): wptr = rptr = 0, buffer empty. After reset, cpbuf_fetch_new_id = 0 and cpbuf_fetch_new_id_valid = 1. Storage contents are not reset; reads of unwritten entries are don't-care.
- cpbuf_fetch_new_id = wptr[ID_WIDTH-1:0], combinational from registers. cpbuf_fetch_new_id_valid = !full.
- Push (push && !full): storage[wptr] <= fetch_cpbuf_data; wptr increments modulo 2*SIZE. Push while full is ignored, with no state change.
- Reads: all cpbuf_*_data outputs are purely combinational, storage[id], with no latency. A write becomes visible on the read port the cycle after its clock edge. There is no same-cycle bypass.
- Rename write: if rename_cpbuf_we[i], storage[rename_cpbuf_id[i]] <= rename_cpbuf_data[i]. Any ID is writable regardless of occupancy.
- Same-entry write collisions: the highest rename port index wins among rename ports. A push wins over any rename write.
- Pop:
  - pop count = number of set bits in commit_cpbuf_pop, clamped to current occupancy.
  - rptr advances by the pop count.
  - Pop on empty is ignored.
- Push and pop in the same cycle both take effect; occupancy changes by push minus pop. Push uses the full state before the edge, so pushing when full is rejected even with a concurrent pop.
- Flush has the highest priority: wptr = rptr = 0, buffer empty, and push/pop in that cycle are ignored. Rename writes in the flush cycle still update storage.
- Wrap-around: after SIZE pushes from empty, wptr index wraps to 0, so new_id = 0 and valid = 0 (full). Subsequent pops clear full, giving new_id = 0 and valid = 1.
- Reset has priority over flush, push, pop and writes to pointers.

Test Plan:
- Reset, then idle one cycle -> new_id = 0, valid = 1.
- Push global_history = 1, then push global_history = 3 on consecutive cycles -> new_id goes 1 then 2, valid stays 1. Reading ID 0 on every read port (rename, exbru, commit) gives 1; reading ID 1 gives 3. Check each port independently while the other ports read the other ID, with a combinational response in the same cycle.
- Rename port i writes ID 0 with global_history = 7 (we[i] for one cycle) -> the next cycle cpbuf_rename_data[i] = 7. Check every port i.
- Assert flush for one cycle with non-empty contents -> new_id = 0, valid = 1 the next cycle.
- From empty, push SIZE times -> new_id goes 0, 1, ... SIZE-1, valid = 1 before each push. Afterwards new_id = 0, valid = 0. A further push leaves the state unchanged.
- Hold pop[0] = 1 for SIZE cycles from full -> after each edge new_id = 0, valid = 1, ending empty.
- Extra: simultaneous push and pop while full (push rejected, pop applied), and multi-bit pop count on a partly filled buffer.
